// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART RX and TX sides.
//   tx_state_t  - serializer states (IDLE, START, DATA, STOP)
//   ASCII_*     - character constants used to print OUT-port values
//   hex_ascii() - maps a nibble to its upper-case ASCII hex character
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic [7:0] ASCII_ZERO      = 8'h30;
  localparam logic [7:0] ASCII_ALPHA_OFS = 8'h37;
  localparam logic [7:0] ASCII_CR        = 8'h0D;
  localparam logic [7:0] ASCII_LF        = 8'h0A;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return ASCII_ZERO + {4'h0, nib};
    else             return ASCII_ALPHA_OFS + {4'h0, nib};
  endfunction

endpackage

// File: rtl/uart_tx.sv
// uart_tx: 8N1 byte serializer, LSB first, line idle high.
//   clk_i    system clock
//   reset_i  synchronous active-high reset; aborts any frame in flight
//   data_i   byte to send, captured when start_i is seen in IDLE
//   start_i  request to send data_i; ignored while ready_o is low
//   ready_o  high only in IDLE
//   tx_o     registered serial line
module uart_tx
  import uart_pkg::*;
#(
  parameter int UART_DATA_LENGTH           = 8,
  parameter int TX_COUNTER_BITWIDTH        = 3,
  parameter int BAUD_COUNTS_PER_BIT        = 521,
  parameter int BAUD_RATE_COUNTER_BITWIDTH = 10
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [UART_DATA_LENGTH-1:0] data_i,
  input  logic                        start_i,
  output logic                        ready_o,
  output logic                        tx_o
);

  localparam logic [BAUD_RATE_COUNTER_BITWIDTH-1:0] BAUD_LAST =
    BAUD_RATE_COUNTER_BITWIDTH'(BAUD_COUNTS_PER_BIT - 1);
  // The line output is registered, so the final stop-bit cycle is driven
  // while the FSM already sits in IDLE. Leaving STOP one count early lets a
  // queued byte start with no gap and keeps a frame at 10 bit times.
  localparam logic [BAUD_RATE_COUNTER_BITWIDTH-1:0] STOP_LAST =
    BAUD_RATE_COUNTER_BITWIDTH'(BAUD_COUNTS_PER_BIT - 2);
  localparam logic [TX_COUNTER_BITWIDTH-1:0] BIT_LAST =
    TX_COUNTER_BITWIDTH'(UART_DATA_LENGTH - 1);

  tx_state_t                              state_q, state_d;
  logic [BAUD_RATE_COUNTER_BITWIDTH-1:0]  baud_q, baud_d;
  logic [TX_COUNTER_BITWIDTH-1:0]         bit_q, bit_d;
  logic [UART_DATA_LENGTH-1:0]            shift_q, shift_d;
  logic                                   tx_q, tx_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = 1'b1;
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        if (start_i) begin
          shift_d = data_i;
          state_d = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) state_d = STOP;
          else                   bit_d   = bit_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_q == STOP_LAST) begin
          baud_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready_o = (state_q == IDLE);
  assign tx_o    = tx_q;

endmodule

// File: rtl/out_port_uart_tx.sv
// out_port_uart_tx: watches the CPU OUT register and prints every value
// change on a UART TX line as one ASCII hex character (8N1, LSB first).
//   clk_i       system clock
//   reset_i     synchronous active-high reset; aborts frame, drops queue
//   out_pins_i  CPU OUT register value
//   tx_o        UART serial line, idle high
//   busy_o      high while a frame is in flight or changes are queued
//   overflow_o  sticky until reset: a change was dropped on a full FIFO
// Build option: define OUT_UART_NEWLINE_EN to follow each hex character
// with CR and LF frames.
module out_port_uart_tx
  import uart_pkg::*;
#(
  parameter int REGISTER_WIDTH             = 4,
  parameter int UART_DATA_LENGTH           = 8,
  parameter int TX_COUNTER_BITWIDTH        = 3,
  parameter int BAUD_COUNTS_PER_BIT        = 521,
  parameter int BAUD_RATE_COUNTER_BITWIDTH = 10,
  parameter int FIFO_DEPTH                 = 4,
  parameter int FIFO_ADDR_WIDTH            = 2
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [REGISTER_WIDTH-1:0] out_pins_i,
  output logic                      tx_o,
  output logic                      busy_o,
  output logic                      overflow_o
);

  logic [REGISTER_WIDTH-1:0] last_q;
  logic [REGISTER_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [FIFO_ADDR_WIDTH:0]  wr_ptr_q, rd_ptr_q;   // extra MSB tells full from empty
  logic                      fifo_empty, fifo_full;
  logic                      change, push, pop;
  logic [REGISTER_WIDTH-1:0] head;
  logic                      tx_ready, tx_start, sub_busy;
  logic [7:0]                tx_byte;
  logic                      busy_q, overflow_q;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[FIFO_ADDR_WIDTH] != rd_ptr_q[FIFO_ADDR_WIDTH]) &&
                      (wr_ptr_q[FIFO_ADDR_WIDTH-1:0] == rd_ptr_q[FIFO_ADDR_WIDTH-1:0]);
  assign head       = fifo_mem[rd_ptr_q[FIFO_ADDR_WIDTH-1:0]];
  assign change     = (out_pins_i != last_q);
  // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
  assign push       = change && (!fifo_full || pop);

`ifdef OUT_UART_NEWLINE_EN
  // 0: hex character (pops the FIFO), 1: CR, 2: LF
  logic [1:0] char_idx_q;

  always_comb begin
    pop      = tx_ready && (char_idx_q == 2'd0) && !fifo_empty;
    tx_start = tx_ready && ((char_idx_q != 2'd0) || !fifo_empty);
    unique case (char_idx_q)
      2'd1:    tx_byte = ASCII_CR;
      2'd2:    tx_byte = ASCII_LF;
      default: tx_byte = hex_ascii(head);
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i)       char_idx_q <= 2'd0;
    else if (tx_start) char_idx_q <= (char_idx_q == 2'd2) ? 2'd0 : char_idx_q + 2'd1;
  end

  assign sub_busy = (char_idx_q != 2'd0);
`else
  assign pop      = tx_ready && !fifo_empty;
  assign tx_start = pop;
  assign tx_byte  = hex_ascii(head);
  assign sub_busy = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      last_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (change) last_q   <= out_pins_i;
      if (push)   wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
      busy_q     <= push || !fifo_empty || !tx_ready || sub_busy;
      overflow_q <= overflow_q || (change && !push);
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are
  // valid, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q[FIFO_ADDR_WIDTH-1:0]] <= out_pins_i;
  end

  uart_tx #(
    .UART_DATA_LENGTH          (UART_DATA_LENGTH),
    .TX_COUNTER_BITWIDTH       (TX_COUNTER_BITWIDTH),
    .BAUD_COUNTS_PER_BIT       (BAUD_COUNTS_PER_BIT),
    .BAUD_RATE_COUNTER_BITWIDTH(BAUD_RATE_COUNTER_BITWIDTH)
  ) u_tx (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .data_i (tx_byte),
    .start_i(tx_start),
    .ready_o(tx_ready),
    .tx_o   (tx_o)
  );

  assign busy_o     = busy_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_out_port_uart_tx.sv
// Bench for out_port_uart_tx at 4 clocks per UART bit. Stimulus pushes the
// expected characters into a queue; a line monitor decodes frames and
// compares them against the queue independently of the stimulus.
`timescale 1ns/1ps
module tb_out_port_uart_tx;

  localparam int N = 4;
`ifdef OUT_UART_NEWLINE_EN
  localparam int FRAMES = 3;
`else
  localparam int FRAMES = 1;
`endif
  localparam int FRAME_CYC = 10 * N;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic [3:0] out_pins_i = 4'h0;
  logic       tx_o, busy_o, overflow_o;

  int         cyc = 0;
  int         checks = 0;
  int         passed = 0;
  logic [7:0] exp_q [$];
  int         starts_q [$];
  bit         mon_en = 1'b1;

  out_port_uart_tx #(.BAUD_COUNTS_PER_BIT(N)) dut (
    .clk_i     (clk),
    .reset_i   (reset_i),
    .out_pins_i(out_pins_i),
    .tx_o      (tx_o),
    .busy_o    (busy_o),
    .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive a new OUT value; k returns the edge number that samples it.
  task automatic change(input logic [3:0] v, output int k);
    out_pins_i = v;
    @(posedge clk);
    #1;
    k = cyc;
  endtask

  task automatic expect_char(input logic [7:0] c);
    exp_q.push_back(c);
`ifdef OUT_UART_NEWLINE_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy_o !== 1'b0 || exp_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_timeout"}, 32'(n < 3000), 32'd1);
    tick(2);
  endtask

  task automatic wait_busy_low(output int c);
    int n = 0;
    @(negedge clk);
    while (busy_o !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    c = cyc;
  endtask

  task automatic check_start(input string name, input int idx, input int exp);
    if (starts_q.size() > idx) check(name, starts_q[idx], exp);
    else begin
      checks++;
      $display("FAIL %s: frame %0d missing, expected start at %0d", name, idx, exp);
    end
  endtask

  // Line monitor: first low seen on a falling edge is offset 0 of a frame;
  // bits are sampled in the middle of each bit time.
  initial begin : monitor
    logic [7:0] b;
    int         t0;
    @(negedge clk);
    forever begin
      if (!mon_en || tx_o !== 1'b0) @(negedge clk);
      else begin
        t0 = cyc;
        repeat (N / 2) @(negedge clk);
        check("start_bit", 32'(tx_o), 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (N) @(negedge clk);
          b[i] = tx_o;
        end
        repeat (N) @(negedge clk);
        check("stop_bit", 32'(tx_o), 32'd1);
        starts_q.push_back(t0);
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_frame: got %0h, expected no frame", b);
        end else begin
          check("frame_byte", 32'(b), 32'(exp_q.pop_front()));
        end
        repeat (N - N / 2) @(negedge clk);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int k, bf, lows, highs;

    // Reset state and a quiet port.
    tick(3);
    check("rst_tx", 32'(tx_o), 32'd1);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_overflow", 32'(overflow_o), 32'd0);
    reset_i = 1'b0;
    lows = 0; highs = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx_o !== 1'b1) lows++;
      if (busy_o !== 1'b0) highs++;
    end
    check("quiet_tx_lows", lows, 0);
    check("quiet_busy_highs", highs, 0);

    // Single change 0 -> A.
    starts_q.delete();
    change(4'hA, k);
    expect_char(8'h41);
    @(negedge clk);
    check("busy_rise", 32'(busy_o), 32'd1);
    wait_busy_low(bf);
    check("busy_fall_cycle", bf, k + 1 + FRAME_CYC * FRAMES);
    wait_idle("single");
    check_start("single_fall", 0, k + 2);

    // Three consecutive changes -> back-to-back frames.
    starts_q.delete();
    change(4'h1, k);
    expect_char(8'h31);
    change(4'h2, bf);
    expect_char(8'h32);
    change(4'h3, bf);
    expect_char(8'h33);
    wait_idle("burst3");
    for (int j = 0; j < 3 * FRAMES; j++) check_start("burst3_start", j, k + 2 + FRAME_CYC * j);
    check("burst3_overflow", 32'(overflow_o), 32'd0);

    // Six changes in six cycles: fifth fills the FIFO, sixth is dropped.
    starts_q.delete();
    change(4'h4, k);
    expect_char(8'h34);
    for (int v = 5; v <= 8; v++) begin
      change(4'(v), bf);
      expect_char(8'h30 + 8'(v));
    end
    check("full_no_overflow", 32'(overflow_o), 32'd0);
    change(4'h9, bf);
    check("overflow_set", 32'(overflow_o), 32'd1);
    wait_idle("overflow");
    for (int j = 0; j < 5 * FRAMES; j++) check_start("overflow_start", j, k + 2 + FRAME_CYC * j);
    check("overflow_sticky", 32'(overflow_o), 32'd1);
    reset_i = 1'b1;
    tick(2);
    check("overflow_cleared", 32'(overflow_o), 32'd0);

    // Released with out_pins_i still at 9: the value is reported.
    starts_q.delete();
    reset_i = 1'b0;
    expect_char(8'h39);
    tick(1);
    k = cyc;
    wait_idle("release");
    check_start("release_fall", 0, k + 2);

    // Reset during DATA bit 3 of 'C' (0x43: bit 3 is 0).
    mon_en = 1'b0;
    change(4'hC, k);
    tick(18);
    check("bit3_low", 32'(tx_o), 32'd0);
    reset_i = 1'b1;
    out_pins_i = 4'h0;
    tick(1);
    check("abort_tx", 32'(tx_o), 32'd1);
    check("abort_busy", 32'(busy_o), 32'd0);
    tick(2);
    reset_i = 1'b0;
    mon_en = 1'b1;
    lows = 0; highs = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_o !== 1'b1) lows++;
      if (busy_o !== 1'b0) highs++;
    end
    check("abort_no_resume", lows, 0);
    check("abort_fifo_empty", highs, 0);

    // Change to F; with newlines enabled this is F, CR, LF contiguously.
    starts_q.delete();
    change(4'hF, k);
    expect_char(8'h46);
    wait_busy_low(bf);
    check("f_busy_fall_cycle", bf, k + 1 + FRAME_CYC * FRAMES);
    wait_idle("char_f");
    for (int j = 0; j < FRAMES; j++) check_start("char_f_start", j, k + 2 + FRAME_CYC * j);

    check("expected_all_sent", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
